// File: rtl/rt_dbg_sba_obi.sv
// System-bus-access responder: decodes DMI accesses to SBCS/SBAddress/SBData and
// issues 32-bit OBI transactions. Define RT_SBA_AUTOINC_EN to enable sbautoincrement.
module rt_dbg_sba_obi #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned RespFifoEn = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dmi_req_valid_i,
    output logic                 dmi_req_ready_o,
    input  logic [6:0]           dmi_req_addr_i,
    input  logic [1:0]           dmi_req_op_i,
    input  logic [31:0]          dmi_req_data_i,
    output logic                 dmi_resp_valid_o,
    input  logic                 dmi_resp_ready_i,
    output logic [31:0]          dmi_resp_data_o,
    output logic [1:0]           dmi_resp_resp_o,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [31:0]          obi_wdata_o,
    input  logic                 obi_rvalid_i,
    input  logic [31:0]          obi_rdata_i,
    input  logic                 obi_err_i
);

    localparam logic [6:0] AddrSbcs  = 7'h38;
    localparam logic [6:0] AddrAddr0 = 7'h39;
    localparam logic [6:0] AddrAddr1 = 7'h3A;
    localparam logic [6:0] AddrData0 = 7'h3C;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] sbaddr_q;
    logic [DataWidth-1:0] sbdata_q;
    logic                 sbreadonaddr_q, sbreadondata_q, sbautoinc_q, sbbusyerror_q;
    logic [2:0]           sbaccess_q, sberror_q;
    logic                 resp_valid_q;
    logic [31:0]          resp_data_q;
    logic                 obi_req_q, obi_we_q;

    logic                 sbbusy, req_fire, is_wr, is_rd;
    logic                 wr_sbcs, wr_addr0, wr_addr1, wr_data0, rd_data0;
    logic                 busy_hit, trigger;
    logic [1:0]           chk_addr;
    logic [31:0]          sbcs_rdata, rd_mux;
    logic [63:0]          addr_ext, addr_lo_new, addr_hi_new;
    logic [AddrWidth-1:0] addr_inc;

    always_comb begin
        sbbusy   = (state_q != StIdle);
        req_fire = dmi_req_valid_i & dmi_req_ready_o;
        is_wr    = req_fire & (dmi_req_op_i == 2'd2);
        is_rd    = req_fire & (dmi_req_op_i == 2'd1);
        wr_sbcs  = is_wr & (dmi_req_addr_i == AddrSbcs);
        wr_addr0 = is_wr & (dmi_req_addr_i == AddrAddr0);
        wr_addr1 = is_wr & (dmi_req_addr_i == AddrAddr1);
        wr_data0 = is_wr & (dmi_req_addr_i == AddrData0);
        rd_data0 = is_rd & (dmi_req_addr_i == AddrData0);

        busy_hit = sbbusy & (wr_addr0 | wr_data0 | rd_data0);
        // A latched error of either kind blocks new accesses until software clears it.
        trigger  = ~sbbusy & (sberror_q == 3'd0) & ~sbbusyerror_q &
                   (wr_data0 | (wr_addr0 & sbreadonaddr_q) | (rd_data0 & sbreadondata_q));
        chk_addr = wr_addr0 ? dmi_req_data_i[1:0] : sbaddr_q[1:0];

        addr_ext    = 64'(sbaddr_q);
        addr_lo_new = {addr_ext[63:32], dmi_req_data_i};
        addr_hi_new = {dmi_req_data_i, addr_ext[31:0]};
        addr_inc    = sbaddr_q + AddrWidth'(4);

        sbcs_rdata = {3'd1, 6'd0, sbbusyerror_q, sbbusy, sbreadonaddr_q, sbaccess_q,
                      sbautoinc_q, sbreadondata_q, sberror_q, 7'(AddrWidth), 5'b00100};

        rd_mux = '0;
        unique case (dmi_req_addr_i)
            AddrSbcs:  rd_mux = sbcs_rdata;
            AddrAddr0: rd_mux = addr_ext[31:0];
            AddrAddr1: rd_mux = addr_ext[63:32];
            AddrData0: rd_mux = sbdata_q;
            default:   rd_mux = '0;
        endcase
    end

    // With the skid enabled a new request may be taken in the cycle the response pops.
    assign dmi_req_ready_o  = (RespFifoEn != 0) ? (~resp_valid_q | dmi_resp_ready_i)
                                                : ~resp_valid_q;
    assign dmi_resp_valid_o = resp_valid_q;
    assign dmi_resp_data_o  = resp_data_q;
    assign dmi_resp_resp_o  = 2'b00;

    assign obi_req_o   = obi_req_q;
    assign obi_addr_o  = {sbaddr_q[AddrWidth-1:2], 2'b00};
    assign obi_we_o    = obi_we_q;
    assign obi_be_o    = 4'hF;
    assign obi_wdata_o = sbdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            sbaddr_q       <= '0;
            sbdata_q       <= '0;
            sbreadonaddr_q <= 1'b0;
            sbreadondata_q <= 1'b0;
            sbautoinc_q    <= 1'b0;
            sbbusyerror_q  <= 1'b0;
            sbaccess_q     <= 3'd0;
            sberror_q      <= 3'd0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            obi_req_q      <= 1'b0;
            obi_we_q       <= 1'b0;
        end else begin
            if (resp_valid_q && dmi_resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            if (req_fire) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= is_rd ? rd_mux : 32'd0;
            end

            if (wr_sbcs) begin
                sbreadonaddr_q <= dmi_req_data_i[20];
                sbaccess_q     <= dmi_req_data_i[19:17];
                sbreadondata_q <= dmi_req_data_i[15];
`ifdef RT_SBA_AUTOINC_EN
                sbautoinc_q    <= dmi_req_data_i[16];
`endif
                if (dmi_req_data_i[22]) begin
                    sbbusyerror_q <= 1'b0;
                end
                sberror_q <= sberror_q & ~dmi_req_data_i[14:12];
            end
            if (busy_hit) begin
                sbbusyerror_q <= 1'b1;
            end

            // Address/data stay frozen while a transaction is in flight.
            if (!sbbusy) begin
                if (wr_addr0) sbaddr_q <= addr_lo_new[AddrWidth-1:0];
                if (wr_addr1) sbaddr_q <= addr_hi_new[AddrWidth-1:0];
                if (wr_data0) sbdata_q <= dmi_req_data_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        if (sbaccess_q != 3'd2) begin
                            sberror_q <= 3'd4;
                        end else if (chk_addr != 2'b00) begin
                            sberror_q <= 3'd3;
                        end else begin
                            state_q   <= StReq;
                            obi_req_q <= 1'b1;
                            obi_we_q  <= wr_data0;
                        end
                    end
                end
                StReq: begin
                    if (obi_gnt_i) begin
                        obi_req_q <= 1'b0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (obi_rvalid_i) begin
                        state_q <= StIdle;
                        if (obi_err_i) begin
                            sberror_q <= 3'd2;
                        end else begin
                            if (!obi_we_q) sbdata_q <= obi_rdata_i;
                            if (sbautoinc_q) sbaddr_q <= addr_inc;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
